// File: rtl/systolic_result_drain.sv
// Snapshots NUM_PE accumulators on cap_valid_i and drains them LSB-first over an 8-bit valid/ready stream.
// Optional header byte {4'hA, seq} per frame when SYSTOLIC_DRAIN_HEADER_EN is defined.
module systolic_result_drain #(
    parameter int NUM_PE = 4,
    parameter int ACC_W  = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cap_valid_i,
    input  logic [NUM_PE*ACC_W-1:0]   acc_flat_i,
    input  logic                      out_ready_i,
    input  logic                      clr_overflow_i,
    output logic [7:0]                out_data_o,
    output logic                      out_valid_o,
    output logic                      out_last_o,
    output logic                      busy_o,
    output logic                      overflow_o
);

    localparam int BYTES = NUM_PE * ACC_W / 8;
`ifdef SYSTOLIC_DRAIN_HEADER_EN
    localparam int TOT = BYTES + 1;
`else
    localparam int TOT = BYTES;
`endif
    localparam int IDX_W = (TOT > 1) ? $clog2(TOT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOT - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_PE*ACC_W-1:0] snap_q, snap_d;
    logic [7:0]              data_q, data_d;
    logic                    last_q, last_d;
    logic                    ovf_q, ovf_d;
`ifdef SYSTOLIC_DRAIN_HEADER_EN
    logic [3:0]              seq_q, seq_d;
`endif

    logic             hs, last_hs, load, advance;
    logic [IDX_W-1:0] sel;

    always_comb begin
        hs      = (state_q == S_SEND) && out_ready_i;
        last_hs = hs && (idx_q == LAST_IDX);
        load    = cap_valid_i && ((state_q == S_IDLE) || last_hs);
        advance = hs && !last_hs;

        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        data_d  = data_q;
        last_d  = last_q;
        ovf_d   = ovf_q;
`ifdef SYSTOLIC_DRAIN_HEADER_EN
        seq_d   = seq_q;
        // Stream index 0 is the header, so data byte for next index equals current index.
        sel     = idx_q;
`else
        sel     = idx_q + IDX_W'(1);
`endif

        // Output byte is only recomputed on load/advance, which keeps it stable through stalls.
        if (load) begin
            state_d = S_SEND;
            idx_d   = '0;
            snap_d  = acc_flat_i;
`ifdef SYSTOLIC_DRAIN_HEADER_EN
            data_d  = {4'hA, seq_q};
            seq_d   = seq_q + 4'd1;
`else
            data_d  = acc_flat_i[7:0];
`endif
            last_d  = (TOT == 1);
        end else if (advance) begin
            idx_d  = idx_q + IDX_W'(1);
            data_d = 8'(snap_q >> {sel, 3'b000});
            last_d = ((idx_q + IDX_W'(1)) == LAST_IDX);
        end else if (last_hs) begin
            state_d = S_IDLE;
            idx_d   = '0;
            data_d  = '0;
            last_d  = 1'b0;
        end

        // A capture that cannot be accepted sets the sticky flag; setting beats clearing.
        if (cap_valid_i && (state_q == S_SEND) && !last_hs) begin
            ovf_d = 1'b1;
        end else if (clr_overflow_i) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            snap_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef SYSTOLIC_DRAIN_HEADER_EN
            seq_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            data_q  <= data_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
`ifdef SYSTOLIC_DRAIN_HEADER_EN
            seq_q   <= seq_d;
`endif
        end
    end

    assign out_data_o  = data_q;
    assign out_valid_o = (state_q == S_SEND);
    assign out_last_o  = last_q;
    assign busy_o      = (state_q == S_SEND);
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed self-checking bench for systolic_result_drain (header mode via SYSTOLIC_DRAIN_HEADER_EN).
module tb_systolic_result_drain;

`ifdef SYSTOLIC_DRAIN_HEADER_EN
    localparam int TOT = 9;
`else
    localparam int TOT = 8;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cap = 1'b0;
    logic [63:0] acc = '0;
    logic        ready = 1'b0;
    logic        clr = 1'b0;
    logic [7:0]  out_data;
    logic        out_valid, out_last, busy, overflow;

    int         n_pass = 0;
    int         n_tot  = 0;
    logic [3:0] seq_tb = '0;

    logic [7:0] fa [8] = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h00, 8'hFF, 8'hFF};
    logic [7:0] fb [8] = '{8'h02, 8'h01, 8'h04, 8'h03, 8'h06, 8'h05, 8'h08, 8'h07};
    localparam logic [63:0] ACC_A = {16'hFFFF, 16'h0001, 16'hABCD, 16'h1234};
    localparam logic [63:0] ACC_B = {16'h0708, 16'h0506, 16'h0304, 16'h0102};
    localparam logic [63:0] ACC_C = {4{16'h5555}};

    always #5 clk = ~clk;

    systolic_result_drain #(.NUM_PE(4), .ACC_W(16)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cap_valid_i    (cap),
        .acc_flat_i     (acc),
        .out_ready_i    (ready),
        .clr_overflow_i (clr),
        .out_data_o     (out_data),
        .out_valid_o    (out_valid),
        .out_last_o     (out_last),
        .busy_o         (busy),
        .overflow_o     (overflow)
    );

    // Stream byte k of a frame built from a hand-written data table.
    function automatic logic [7:0] sbyte(input logic [7:0] t [8], input logic [3:0] s, input int k);
`ifdef SYSTOLIC_DRAIN_HEADER_EN
        if (k == 0) return {4'hA, s};
        return t[k-1];
`else
        if (s == 4'hF) return t[k];
        return t[k];
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [63:0] a, output logic [3:0] s);
        s      = seq_tb;
        seq_tb = seq_tb + 4'd1;
        cap    = 1'b1;
        acc    = a;
        tick();
        cap    = 1'b0;
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        seq_tb = '0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        n_tot++;
        if ({out_data, out_valid, out_last, busy, overflow} !== 12'h000) begin
            $display("FAIL reset_outputs got d=%h v=%b l=%b b=%b o=%b exp all 0",
                     out_data, out_valid, out_last, busy, overflow);
        end else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [3:0] s;
        ready = 1'b1;
        capture(ACC_A, s);
        for (int k = 0; k < TOT; k++) begin
            n_tot++;
            if ({out_valid, out_last, busy, out_data} !== {1'b1, (k == TOT-1), 1'b1, sbyte(fa, s, k)}) begin
                $display("FAIL basic_byte%0d got v=%b l=%b b=%b d=%h exp v=1 l=%b b=1 d=%h",
                         k, out_valid, out_last, busy, out_data, (k == TOT-1), sbyte(fa, s, k));
            end else n_pass++;
            tick();
        end
        n_tot++;
        if ({out_valid, out_last, busy} !== 3'b000) begin
            $display("FAIL basic_idle got v=%b l=%b b=%b exp 000", out_valid, out_last, busy);
        end else n_pass++;
    endtask

    task automatic test_stall();
        logic [3:0] s;
        int k = 0;
        int c = 0;
        capture(ACC_A, s);
        while (k < TOT && c < 64) begin
            ready = ((c % 4) == 0) || ((c % 4) == 3);
            n_tot++;
            if ({out_valid, out_last, out_data} !== {1'b1, (k == TOT-1), sbyte(fa, s, k)}) begin
                $display("FAIL stall_c%0d_byte%0d got v=%b l=%b d=%h exp v=1 l=%b d=%h",
                         c, k, out_valid, out_last, out_data, (k == TOT-1), sbyte(fa, s, k));
            end else n_pass++;
            tick();
            if (ready) k++;
            c++;
        end
        n_tot++;
        if (k != TOT || out_valid !== 1'b0) begin
            $display("FAIL stall_end got bytes=%0d v=%b exp bytes=%0d v=0", k, out_valid, TOT);
        end else n_pass++;
        ready = 1'b1;
    endtask

    task automatic test_overflow();
        logic [3:0] s;
        logic       ovf_exp = 1'b0;
        ready = 1'b1;
        capture(ACC_A, s);
        for (int k = 0; k < TOT; k++) begin
            n_tot++;
            if ({out_valid, out_last, out_data, overflow} !== {1'b1, (k == TOT-1), sbyte(fa, s, k), ovf_exp}) begin
                $display("FAIL ovf_byte%0d got v=%b l=%b d=%h o=%b exp v=1 l=%b d=%h o=%b",
                         k, out_valid, out_last, out_data, overflow, (k == TOT-1), sbyte(fa, s, k), ovf_exp);
            end else n_pass++;
            if (k == 2) begin cap = 1'b1; acc = ACC_C; end
            if (k == 4) clr = 1'b1;
            if (k == 5) begin cap = 1'b1; clr = 1'b1; end
            tick();
            cap = 1'b0;
            clr = 1'b0;
            if (k == 2 || k == 5) ovf_exp = 1'b1;
            if (k == 4) ovf_exp = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            n_tot++;
            if ({out_valid, busy, overflow} !== 3'b001) begin
                $display("FAIL ovf_nosecond%0d got v=%b b=%b o=%b exp v=0 b=0 o=1", i, out_valid, busy, overflow);
            end else n_pass++;
            tick();
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_tot++;
        if (overflow !== 1'b0) begin
            $display("FAIL ovf_clear got o=%b exp o=0", overflow);
        end else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] sa, sb;
        ready = 1'b1;
        capture(ACC_A, sa);
        for (int k = 0; k < TOT; k++) begin
            n_tot++;
            if ({out_valid, out_last, out_data} !== {1'b1, (k == TOT-1), sbyte(fa, sa, k)}) begin
                $display("FAIL b2b_a%0d got v=%b l=%b d=%h exp v=1 l=%b d=%h",
                         k, out_valid, out_last, out_data, (k == TOT-1), sbyte(fa, sa, k));
            end else n_pass++;
            if (k == TOT-1) begin
                sb = seq_tb;
                seq_tb = seq_tb + 4'd1;
                cap = 1'b1;
                acc = ACC_B;
            end
            tick();
            cap = 1'b0;
        end
        for (int k = 0; k < TOT; k++) begin
            n_tot++;
            if ({out_valid, out_last, out_data, overflow} !== {1'b1, (k == TOT-1), sbyte(fb, sb, k), 1'b0}) begin
                $display("FAIL b2b_b%0d got v=%b l=%b d=%h o=%b exp v=1 l=%b d=%h o=0",
                         k, out_valid, out_last, out_data, overflow, (k == TOT-1), sbyte(fb, sb, k));
            end else n_pass++;
            tick();
        end
        n_tot++;
        if ({out_valid, busy} !== 2'b00) begin
            $display("FAIL b2b_idle got v=%b b=%b exp 00", out_valid, busy);
        end else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [3:0] s;
        ready = 1'b1;
        capture(ACC_A, s);
        tick();
        tick();
        tick();
        ready = 1'b0;
        tick();
        tick();
        n_tot++;
        if ({out_valid, out_data} !== {1'b1, sbyte(fa, s, 3)}) begin
            $display("FAIL rstmid_stall got v=%b d=%h exp v=1 d=%h", out_valid, out_data, sbyte(fa, s, 3));
        end else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_tot++;
        if ({out_valid, busy, out_last, out_data} !== 11'h000) begin
            $display("FAIL rstmid_async got v=%b b=%b l=%b d=%h exp all 0", out_valid, busy, out_last, out_data);
        end else n_pass++;
        #1 rst = 1'b0;
        seq_tb = '0;
        ready = 1'b1;
        tick();
        n_tot++;
        if ({out_valid, busy} !== 2'b00) begin
            $display("FAIL rstmid_noresume got v=%b b=%b exp 00", out_valid, busy);
        end else n_pass++;
        capture(ACC_B, s);
        n_tot++;
        if ({out_valid, out_data} !== {1'b1, sbyte(fb, s, 0)}) begin
            $display("FAIL rstmid_fresh got v=%b d=%h exp v=1 d=%h", out_valid, out_data, sbyte(fb, s, 0));
        end else n_pass++;
        tick();
        n_tot++;
        if ({out_valid, out_data} !== {1'b1, sbyte(fb, s, 1)}) begin
            $display("FAIL rstmid_fresh1 got v=%b d=%h exp v=1 d=%h", out_valid, out_data, sbyte(fb, s, 1));
        end else n_pass++;
        for (int k = 1; k < TOT; k++) tick();
    endtask

`ifdef SYSTOLIC_DRAIN_HEADER_EN
    task automatic test_header();
        logic [3:0] s;
        logic [7:0] hdr_exp [17] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8,
                                     8'hA9, 8'hAA, 8'hAB, 8'hAC, 8'hAD, 8'hAE, 8'hAF, 8'hA0};
        do_reset();
        ready = 1'b1;
        for (int f = 0; f < 17; f++) begin
            capture(ACC_B, s);
            n_tot++;
            if ({out_valid, out_data} !== {1'b1, hdr_exp[f]}) begin
                $display("FAIL header_f%0d got v=%b d=%h exp v=1 d=%h", f, out_valid, out_data, hdr_exp[f]);
            end else n_pass++;
            for (int k = 0; k < TOT; k++) tick();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
`ifdef SYSTOLIC_DRAIN_HEADER_EN
        test_header();
`endif
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
- Output stage directly downstream of the systolic PE chain.
- When the chain signals its accumulators are final, the block snapshots all NUM_PE results.
- It then serialises them byte-by-byte onto an 8-bit valid/ready stream that drives the tile's uo_out pins.
- The chain can start the next computation as soon as the snapshot is taken.

Parameters:
- NUM_PE, 4, number of PEs / accumulator words captured per frame.
- ACC_W, 16, accumulator width per PE in bits; must be a multiple of 8.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cap_valid  in  1  single-cycle pulse from chain: acc_flat is final this cycle.
- acc_flat  in  NUM_PE*ACC_W  packed accumulators; PE i at bits [i*ACC_W +: ACC_W].
- out_ready  in  1  downstream accepts the current byte.
- clr_overflow  in  1  clears the sticky overflow flag.
- out_data  out  8  current output byte.
- out_valid  out  1  out_data is valid.
- out_last  out  1  current byte is the final byte of the frame.
- busy  out  1  a frame is held or being sent.
- overflow  out  1  sticky: a capture was dropped.

Behaviour:
- Reset (asynchronous, immediate): out_data=0, out_valid=0, out_last=0, busy=0, overflow=0, byte index=0, state=IDLE, snapshot register=0.
- Frame length: BYTES = NUM_PE*ACC_W/8.
- Byte order: PE0 first, least-significant byte first within each word. Byte k = snapshot[8k +: 8].
- States:
  - IDLE: on cap_valid, latch acc_flat into the snapshot, set index=0, go to SEND.
  - SEND: out_valid=1 and out_data=byte[index]. Handshake fires when out_valid && out_ready.
    - On handshake with index<BYTES-1: index increments.
    - On handshake with index==BYTES-1: return to IDLE.
- Latency: cap_valid in cycle N gives out_valid=1 with byte 0 in cycle N+1. With out_ready held high, one byte per cycle; last byte in cycle N+BYTES.
- Stall: while out_valid=1 and out_ready=0, out_data, out_last and index hold stable (standard AXI-stream rule). out_valid never drops before its handshake.
- out_last=1 only while index==BYTES-1 in SEND.
- busy=1 in SEND, otherwise 0.
- cap_valid while in SEND, not on the final handshake cycle: capture dropped, overflow<=1, the frame in flight is unaffected.
- cap_valid in the same cycle as the final handshake: accepted (back-to-back). Snapshot reloads, index=0, stay in SEND, byte 0 of the new frame appears next cycle with no bubble. overflow unchanged.
- clr_overflow and a drop event in the same cycle: overflow stays 1 (set wins).
- All outputs are registered; no combinational path from out_ready to out_valid.
- Reset asserted mid-frame: frame abandoned, outputs return to reset values immediately. No partial resume after reset deasserts.

Optional Feature:
- Macro: SYSTOLIC_DRAIN_HEADER_EN.
- When defined:
  - Each frame is prefixed by one header byte {4'hA, seq[3:0]}.
  - seq is a 4-bit frame counter: reset 0, increments on each accepted capture, wraps 15->0.
  - Frame length becomes BYTES+1; the header is sent in cycle N+1 and data bytes shift one cycle later.
  - out_last is still asserted on the final data byte.
- When undefined: no header, no seq register, timing exactly as in Behaviour.

Test Plan:
1. Reset, then cap_valid with PE0..3 = 0x1234, 0xABCD, 0x0001, 0xFFFF and out_ready=1 -> bytes 34 12 CD AB 01 00 FF FF in consecutive cycles N+1..N+8; out_last only on the 8th byte; busy falls after it.
2. Same frame with out_ready toggled 1,0,0,1,... -> byte sequence identical; out_data stable through every stall; no byte lost or duplicated.
3. Second cap_valid (all PEs 0x5555) three cycles into a frame -> first frame unaffected; overflow=1; no second frame. Then clr_overflow -> overflow=0.
4. New cap_valid (PEs 0x0102, 0x0304, 0x0506, 0x0708) coincident with the final handshake -> next cycle out_data=0x02; frame 02 01 04 03 06 05 08 07 follows with no gap; overflow remains 0.
5. rst pulsed while byte 3 is held stalled -> out_valid=0, busy=0 immediately. A fresh capture afterwards starts at byte 0.
6. With SYSTOLIC_DRAIN_HEADER_EN, three frames -> headers A0, A1, A2; with 17 frames, the 17th header is A0 (wrap).
